// File: rtl/vending_pkg.sv
// Shared constants and state encoding for the 15-unit single-product vending controller.
package vending_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S0  = 2'b00;
  localparam state_t S5  = 2'b01;
  localparam state_t S10 = 2'b10;
  localparam state_t SIll = 2'b11;

  localparam int unsigned COIN_5  = 5;
  localparam int unsigned COIN_10 = 10;
  localparam int unsigned PRICE   = 15;

  function automatic logic [4:0] state_credit(input state_t st);
    unique case (st)
      S5:      state_credit = 5'(COIN_5);
      S10:     state_credit = 5'(COIN_10);
      default: state_credit = 5'd0;
    endcase
  endfunction

  function automatic state_t credit_state(input logic [4:0] credit);
    case (credit)
      5'(COIN_5):  credit_state = S5;
      5'(COIN_10): credit_state = S10;
      default:     credit_state = S0;
    endcase
  endfunction

endpackage

// File: rtl/vending_machine.sv
// Coin-accepting vending FSM: tracks credit in 5-unit steps, pulses dout on a sale and
// ret when 20 units were paid.
module vending_machine
  import vending_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i,
  input  logic j,
  output logic dout,
  output logic ret
);

  state_t     ps;
  state_t     ps_d;
  logic       dout_d;
  logic       ret_d;
  logic [4:0] coin_val;
  logic [4:0] credit_sum;

  always_comb begin
    coin_val = 5'd0;
    // Simultaneous or unknown strobes fall to default and count as no coin.
    case ({i, j})
      2'b10:   coin_val = 5'(COIN_5);
      2'b01:   coin_val = 5'(COIN_10);
      default: coin_val = 5'd0;
    endcase
  end

  assign credit_sum = state_credit(ps) + coin_val;

  always_comb begin
    ps_d   = ps;
    dout_d = 1'b0;
    ret_d  = 1'b0;
    if (ps == SIll) begin
      ps_d = S0;
    end else if (credit_sum >= 5'(PRICE)) begin
      ps_d   = S0;
      dout_d = 1'b1;
      ret_d  = (credit_sum > 5'(PRICE));
    end else begin
      ps_d = credit_state(credit_sum);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps   <= S0;
      dout <= 1'b0;
      ret  <= 1'b0;
    end else begin
      ps   <= ps_d;
      dout <= dout_d;
      ret  <= ret_d;
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Randomized and directed bench for vending_machine against an integer-credit reference model.
module tb_vending_machine;

  logic clk;
  logic rst;
  logic i;
  logic j;
  logic dout;
  logic ret;

  int unsigned n_checks;
  int unsigned n_errors;

  int   credit;
  logic exp_dout;
  logic exp_ret;

  vending_machine dut (
    .clk  (clk),
    .rst  (rst),
    .i    (i),
    .j    (j),
    .dout (dout),
    .ret  (ret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: credit as a plain integer; a sale happens whenever it reaches the price.
  task automatic model_step(input logic ii, input logic jj);
    exp_dout = 1'b0;
    exp_ret  = 1'b0;
    if (ii && !jj) credit += 5;
    else if (jj && !ii) credit += 10;
    if (credit >= 15) begin
      exp_dout = 1'b1;
      exp_ret  = (credit > 15);
      credit   = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".ps"}, 32'(dut.ps), 32'(credit / 5));
    check_eq({tag, ".dout"}, 32'(dout), 32'(exp_dout));
    check_eq({tag, ".ret"}, 32'(ret), 32'(exp_ret));
  endtask

  // Called just after a rising edge; presents a coin, advances one clock, checks.
  task automatic step(input logic ii, input logic jj, input string tag);
    i = ii;
    j = jj;
    @(posedge clk);
    model_step(ii, jj);
    #1;
    check_all(tag);
  endtask

  // Mid-cycle asynchronous reset with a coin offered while held, released mid-cycle.
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    credit   = 0;
    exp_dout = 1'b0;
    exp_ret  = 1'b0;
    check_all({tag, ".async"});
    i = 1'b0;
    j = 1'b1;
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    #2;
    rst = 1'b0;
    i   = 1'b0;
    j   = 1'b0;
    @(posedge clk);
    #1;
    check_all({tag, ".rel"});
  endtask

  initial begin
    logic ri;
    logic rj;
    n_checks = 0;
    n_errors = 0;
    credit   = 0;
    exp_dout = 1'b0;
    exp_ret  = 1'b0;
    rst = 1'b1;
    i   = 1'b0;
    j   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("por");
    rst = 1'b0;
    step(1'b0, 1'b0, "idle0");
    step(1'b0, 1'b0, "idle1");

    // Reset while dout is high must clear it without a clock edge.
    step(1'b0, 1'b1, "pre10");
    step(1'b1, 1'b0, "pre5");
    mid_reset("rst_dout");
    step(1'b0, 1'b0, "idle2");

    step(1'b1, 1'b0, "a5");
    step(1'b1, 1'b0, "a10");
    step(1'b1, 1'b0, "a15");
    step(1'b0, 1'b0, "a_after");

    step(1'b0, 1'b1, "b10");
    step(1'b1, 1'b0, "b15");
    step(1'b0, 1'b0, "b_after");

    step(1'b0, 1'b1, "c10");
    step(1'b0, 1'b1, "c20");
    step(1'b0, 1'b0, "c_after");

    step(1'b1, 1'b0, "d5");
    step(1'b0, 1'b1, "d15");
    step(1'b0, 1'b1, "d_b2b");
    step(1'b0, 1'b0, "d_hold");
    step(1'b1, 1'b0, "d_sale");

    step(1'b1, 1'b0, "e5");
    step(1'b1, 1'b1, "e_ill");
    step(1'b1, 1'b1, "e_ill2");
    step(1'b0, 1'b0, "e_hold");

    step(1'b1, 1'b0, "f10");
    mid_reset("rst_s10");

    for (int k = 0; k < 300; k++) begin
      ri = 1'($urandom_range(0, 1));
      rj = 1'($urandom_range(0, 1));
      step(ri, rj, $sformatf("rnd%0d", k));
      if (($urandom_range(0, 49)) == 0) mid_reset($sformatf("rnd_rst%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
